// File: rtl/traffic_phase_controller.sv
// Two-approach traffic sequencer with pedestrian walk service and side-street sensor extension.
// Optional all-red clearance after each yellow is built when TLC_ALL_RED_EN is defined.
module traffic_phase_controller #(
  parameter int unsigned INIT_GREEN_T = 12,
  parameter int unsigned GREEN_T      = 6,
  parameter int unsigned EXT_T        = 3,
  parameter int unsigned YELLOW_T     = 2,
  parameter int unsigned WALK_T       = 3,
  parameter int unsigned ALLRED_T     = 1,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       sensor,
  input  logic       walk_btn,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk_lamp,
  output logic       walk_pending,
  output logic [3:0] phase
);

  localparam int unsigned T_MAX = (32'd1 << CNT_W) - 32'd1;

  if (INIT_GREEN_T < 1 || INIT_GREEN_T > T_MAX || GREEN_T < 1 || GREEN_T > T_MAX ||
      EXT_T < 1 || EXT_T > T_MAX || YELLOW_T < 1 || YELLOW_T > T_MAX ||
      WALK_T < 1 || WALK_T > T_MAX || ALLRED_T < 1 || ALLRED_T > T_MAX) begin : g_bad_duration
    $error("traffic_phase_controller: phase duration outside 1..2^CNT_W-1");
  end

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    GMI    = 4'd1,
    GMA    = 4'd2,
    GME    = 4'd3,
    YM     = 4'd4,
    GS     = 4'd5,
    GSE    = 4'd6,
    YS     = 4'd7,
`ifdef TLC_ALL_RED_EN
    WALK   = 4'd8,
    ALLRED = 4'd9
`else
    WALK   = 4'd8
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] lim;
  logic             btn_q;
  logic             exit_now;
`ifdef TLC_ALL_RED_EN
  state_t           ar_dest;
`endif

  function automatic logic [2:0] main_dec(input state_t s);
    case (s)
      INIT:          main_dec = 3'b000;
      GMI, GMA, GME: main_dec = 3'b100;
      YM:            main_dec = 3'b010;
      default:       main_dec = 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] side_dec(input state_t s);
    case (s)
      INIT:    side_dec = 3'b000;
      GS, GSE: side_dec = 3'b100;
      YS:      side_dec = 3'b010;
      default: side_dec = 3'b001;
    endcase
  endfunction

  // Terminal count of the shared phase timer; INIT leaves on the very first tick.
  always_comb begin
    lim = '0;
    case (state)
      GMI:      lim = CNT_W'(INIT_GREEN_T - 1);
      GMA, GS:  lim = CNT_W'(GREEN_T - 1);
      GME, GSE: lim = CNT_W'(EXT_T - 1);
      YM, YS:   lim = CNT_W'(YELLOW_T - 1);
      WALK:     lim = CNT_W'(WALK_T - 1);
`ifdef TLC_ALL_RED_EN
      ALLRED:   lim = CNT_W'(ALLRED_T - 1);
`endif
      default:  lim = '0;
    endcase
  end

  assign exit_now = tick && (tmr == lim);

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (exit_now) state_nxt = GMI;
      GMI:  if (exit_now) state_nxt = YM;
      GMA:  if (exit_now) state_nxt = sensor ? GME : YM;
      GME:  if (exit_now) state_nxt = YM;
      GS:   if (exit_now) state_nxt = sensor ? GSE : YS;
      GSE:  if (exit_now) state_nxt = YS;
      WALK: if (exit_now) state_nxt = GS;
`ifdef TLC_ALL_RED_EN
      YM:     if (exit_now) state_nxt = ALLRED;
      YS:     if (exit_now) state_nxt = ALLRED;
      ALLRED: if (exit_now) state_nxt = ar_dest;
`else
      YM:   if (exit_now) state_nxt = walk_pending ? WALK : GS;
      YS:   if (exit_now) state_nxt = GMA;
`endif
      default: state_nxt = INIT;
    endcase
  end

  // Lamps are registered from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      tmr          <= '0;
      btn_q        <= 1'b0;
      walk_pending <= 1'b0;
      main_lamp    <= 3'b000;
      side_lamp    <= 3'b000;
      walk_lamp    <= 1'b0;
`ifdef TLC_ALL_RED_EN
      ar_dest      <= GS;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tmr <= '0;
      end else if (tick) begin
        tmr <= tmr + 1'b1;
      end
      btn_q <= walk_btn;
      // Entering WALK serves the request and wins over a press sampled on the same edge.
      if (state_nxt == WALK && state != WALK) begin
        walk_pending <= 1'b0;
      end else if (walk_btn && !btn_q) begin
        walk_pending <= 1'b1;
      end
`ifdef TLC_ALL_RED_EN
      if (state == YM && exit_now) begin
        ar_dest <= walk_pending ? WALK : GS;
      end else if (state == YS && exit_now) begin
        ar_dest <= GMA;
      end
`endif
      main_lamp <= main_dec(state_nxt);
      side_lamp <= side_dec(state_nxt);
      walk_lamp <= (state_nxt == WALK);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Randomised and scripted bench for traffic_phase_controller; a countdown phase model
// queues each expected transition and a monitor compares every observed phase change.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_btn = 1'b0;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk_lamp;
  logic       walk_pending;
  logic [3:0] phase;

  traffic_phase_controller #(
    .INIT_GREEN_T(12), .GREEN_T(6), .EXT_T(3), .YELLOW_T(2),
    .WALK_T(3), .ALLRED_T(1), .CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sensor(sensor), .walk_btn(walk_btn),
    .main_lamp(main_lamp), .side_lamp(side_lamp), .walk_lamp(walk_lamp),
    .walk_pending(walk_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int P_INIT = 0, P_GMI = 1, P_GMA = 2, P_GME = 3, P_YM = 4,
                 P_GS = 5, P_GSE = 6, P_YS = 7, P_WALK = 8;
`ifdef TLC_ALL_RED_EN
  localparam int P_ALLRED = 9;
`endif

  typedef struct {
    int         cyc;
    int         ph;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wl;
    logic       wp;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: phase name plus ticks remaining in it.
  int m_st, m_rem, m_dest;
  bit m_pend, m_prev;
  int tc = 0;

  function automatic int dur(input int s);
    case (s)
      P_GMI:         dur = 12;
      P_GMA, P_GS:   dur = 6;
      P_GME, P_GSE:  dur = 3;
      P_YM, P_YS:    dur = 2;
      P_WALK:        dur = 3;
      default:       dur = 1;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int s);
    if (s == P_INIT) exp_main = 3'b000;
    else if (s == P_GMI || s == P_GMA || s == P_GME) exp_main = 3'b100;
    else if (s == P_YM) exp_main = 3'b010;
    else exp_main = 3'b001;
  endfunction

  function automatic logic [2:0] exp_side(input int s);
    if (s == P_INIT) exp_side = 3'b000;
    else if (s == P_GS || s == P_GSE) exp_side = 3'b100;
    else if (s == P_YS) exp_side = 3'b010;
    else exp_side = 3'b001;
  endfunction

  task automatic push_exp(input int c);
    exp_t e;
    e.cyc = c;
    e.ph  = m_st;
    e.ml  = exp_main(m_st);
    e.sl  = exp_side(m_st);
    e.wl  = (m_st == P_WALK);
    e.wp  = m_pend;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_st = P_INIT; m_rem = 1; m_pend = 0; m_prev = 0; m_dest = P_GS;
  endtask

  task automatic model_step(input bit t, input bit s, input bit b);
    int nx;
    bit rise;
    nx = m_st;
    rise = b && !m_prev;
    if (t) begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_st)
          P_INIT:       nx = P_GMI;
          P_GMI, P_GME: nx = P_YM;
          P_GMA:        nx = s ? P_GME : P_YM;
          P_GS:         nx = s ? P_GSE : P_YS;
          P_GSE:        nx = P_YS;
          P_WALK:       nx = P_GS;
`ifdef TLC_ALL_RED_EN
          P_YM:     begin nx = P_ALLRED; m_dest = m_pend ? P_WALK : P_GS; end
          P_YS:     begin nx = P_ALLRED; m_dest = P_GMA; end
          P_ALLRED: nx = m_dest;
`else
          P_YM:     nx = m_pend ? P_WALK : P_GS;
          P_YS:     nx = P_GMA;
`endif
          default:  nx = P_INIT;
        endcase
      end
    end
    if (nx == P_WALK && m_st != P_WALK) m_pend = 0;
    else if (rise) m_pend = 1;
    m_prev = b;
    if (nx != m_st) begin
      m_st  = nx;
      m_rem = dur(nx);
      push_exp(cyc + 1);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit t, input bit s, input bit b);
    tick = t; sensor = s; walk_btn = b;
    model_step(t, s, b);
    @(negedge clk);
  endtask

  task automatic dstep(input bit s, input bit b);
    bit t;
    t  = (tc == 9);
    tc = (tc + 1) % 10;
    step(t, s, b);
  endtask

  task automatic run_until(input int target, input bit s, input bit b);
    int i;
    i = 0;
    while (m_st != target && i < 3000) begin
      dstep(s, b);
      i++;
    end
    if (m_st != target) begin
      n_chk++;
      $display("FAIL reach_state: model stuck in %0d waiting for %0d", m_st, target);
    end
  endtask

  task automatic run_random(input int n);
    bit rs, rb;
    rs = sensor; rb = walk_btn;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) rs = !rs;
      if ($urandom_range(0, 19) == 0) rb = !rb;
      step($urandom_range(0, 3) == 0, rs, rb);
    end
  endtask

  int last_ph = 0;
  always @(negedge clk) begin
    exp_t e;
    if (32'(phase) != last_ph) begin
      last_ph = 32'(phase);
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_transition: got phase %0d expected no change (cycle %0d)", phase, cyc);
      end else begin
        e = q.pop_front();
        chk("phase",        32'(phase),        32'(e.ph));
        chk("change_cycle", cyc,               e.cyc);
        chk("main_lamp",    32'(main_lamp),    32'(e.ml));
        chk("side_lamp",    32'(side_lamp),    32'(e.sl));
        chk("walk_lamp",    32'(walk_lamp),    32'(e.wl));
        chk("walk_pending", 32'(walk_pending), 32'(e.wp));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_phase",   32'(phase),        0);
    chk("reset_main",    32'(main_lamp),    0);
    chk("reset_side",    32'(side_lamp),    0);
    chk("reset_walk",    32'(walk_lamp),    0);
    chk("reset_pending", 32'(walk_pending), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tc = 0;

    // Walk press mid-GMI, then sensor extension of side green.
    run_until(P_GMI, 0, 0);
    repeat (50) dstep(0, 0);
    dstep(0, 1);
    dstep(0, 0);
    run_until(P_WALK, 0, 0);
    run_until(P_GS, 0, 0);
    run_until(P_GSE, 1, 0);
    run_until(P_YS, 0, 0);
    run_until(P_GMA, 0, 0);
    run_until(P_YM, 0, 0);

    // Held button requests once; a press during WALK queues another walk.
    repeat (1000) dstep(0, 1);
    dstep(0, 0);
    dstep(0, 1);
    run_until(P_WALK, 0, 0);
    repeat (12) dstep(0, 0);
    dstep(0, 1);
    dstep(0, 0);
    run_until(P_GS, 0, 0);
    run_until(P_WALK, 0, 0);

    // Press landing on the yellow exit edge that enters WALK.
    dstep(0, 1);
    dstep(0, 0);
    run_until(P_YM, 0, 0);
    i = 0;
    while (!(tc == 9 && m_rem == 1) && i < 100) begin
      dstep(0, 0);
      i++;
    end
    dstep(0, 1);
    dstep(0, 0);
    run_until(P_GMA, 0, 0);
    run_until(P_GMA, 0, 0);

    run_random(4000);

    // Asynchronous reset mid side-green.
    run_until(P_GS, 0, 1);
    repeat (25) dstep(0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_main",    32'(main_lamp),    0);
    chk("async_side",    32'(side_lamp),    0);
    chk("async_walk",    32'(walk_lamp),    0);
    chk("async_phase",   32'(phase),        0);
    chk("async_pending", 32'(walk_pending), 0);
    model_reset();
    push_exp(cyc + 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; walk_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tc = 0;
    run_until(P_YM, 0, 0);

    run_random(2000);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
